// File: rtl/nand_behavioral_unit.sv
// Bitwise 2-input NAND with a zero-latency combinational output, plus a
// registered copy of the result and a saturating count of all-zero cycles.
module nand_behavioral_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] low_cnt
);

    logic [WIDTH-1:0] y_reg_q;
    logic [WIDTH-1:0] y_reg_d;
    logic [CNT_W-1:0] low_cnt_q;
    logic [CNT_W-1:0] low_cnt_d;
    logic             y_all_zero;
    logic             cnt_at_max;

    // Plain continuous assignment so X/Z propagate with native & and ~ semantics.
    assign Y = ~(A & B);

    assign y_all_zero = (Y == '0);
    assign cnt_at_max = (low_cnt_q == '1);

    always_comb begin
        y_reg_d   = Y;
        low_cnt_d = low_cnt_q;
        // An unknown Y makes the compare non-true, so the counter holds.
        if (y_all_zero && !cnt_at_max) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    // Reset value of the register is the NAND of 0,0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg_q   <= '1;
            low_cnt_q <= '0;
        end else begin
            y_reg_q   <= y_reg_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign y_q     = y_reg_q;
    assign low_cnt = low_cnt_q;

endmodule

// File: tb/tb_nand_behavioral_unit.sv
// Directed bench for nand_behavioral_unit: combinational sweep, register path,
// counter saturation, asynchronous reset mid-run and a 4-bit instance.
`timescale 1ns/1ps
module tb_nand_behavioral_unit;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic       y_s, yq_s;
    logic [1:0] cnt_s;
    logic       y_p, yq_p;
    logic [7:0] cnt_p;
    logic [3:0] a4, b4, y_4, yq_4;
    logic [7:0] cnt_4;

    int n_cmp;
    int n_mis;

    // WIDTH=1 with a 2-bit counter so saturation is reachable quickly.
    nand_behavioral_unit #(.WIDTH(1), .CNT_W(2)) u_s (
        .Y(y_s), .A(a1), .B(b1), .clk(clk), .rst(rst),
        .y_q(yq_s), .low_cnt(cnt_s)
    );

    // Positional hookup checks the declared port order Y, A, B, clk, rst, y_q, low_cnt.
    nand_behavioral_unit u_pos (y_p, a1, b1, clk, rst, yq_p, cnt_p);

    nand_behavioral_unit #(.WIDTH(4)) u_w4 (
        .Y(y_4), .A(a4), .B(b4), .clk(clk), .rst(rst),
        .y_q(yq_4), .low_cnt(cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        #3;
        n_cmp++; if (yq_s !== 1'b1)  begin n_mis++; $display("FAIL reset_yq_s: got %b need 1", yq_s); end
        n_cmp++; if (cnt_s !== 2'd0) begin n_mis++; $display("FAIL reset_cnt_s: got %0d need 0", cnt_s); end
        n_cmp++; if (yq_4 !== 4'hF)  begin n_mis++; $display("FAIL reset_yq_4: got %h need f", yq_4); end
        n_cmp++; if (cnt_4 !== 8'd0) begin n_mis++; $display("FAIL reset_cnt_4: got %0d need 0", cnt_4); end
        n_cmp++; if (yq_p !== 1'b1)  begin n_mis++; $display("FAIL reset_yq_pos: got %b need 1", yq_p); end
    endtask

    // Run while rst is high so only the combinational path can change anything.
    task automatic test_comb_sweep();
        logic [1:0] va [4];
        logic       ve [4];
        va[0] = 2'b00; ve[0] = 1'b1;
        va[1] = 2'b01; ve[1] = 1'b1;
        va[2] = 2'b10; ve[2] = 1'b1;
        va[3] = 2'b11; ve[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = va[i][1]; b1 = va[i][0];
            #0;
            #0;
            n_cmp++; if (y_s !== ve[i]) begin n_mis++; $display("FAIL comb_same_step %0d: got %b need %b", i, y_s, ve[i]); end
            #1;
            n_cmp++; if (y_s !== ve[i]) begin n_mis++; $display("FAIL comb_sweep %0d: got %b need %b", i, y_s, ve[i]); end
            n_cmp++; if (y_p !== ve[i]) begin n_mis++; $display("FAIL comb_sweep_pos %0d: got %b need %b", i, y_p, ve[i]); end
        end
        n_cmp++; if (yq_s !== 1'b1) begin n_mis++; $display("FAIL comb_reset_hold_yq: got %b need 1", yq_s); end
    endtask

    task automatic test_register_path();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (yq_s !== 1'b0)  begin n_mis++; $display("FAIL reg_yq_low: got %b need 0", yq_s); end
        n_cmp++; if (cnt_s !== 2'd1) begin n_mis++; $display("FAIL reg_cnt_first: got %0d need 1", cnt_s); end
        n_cmp++; if (yq_p !== 1'b0)  begin n_mis++; $display("FAIL reg_yq_pos: got %b need 0", yq_p); end
        @(negedge clk);
        a1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (yq_s !== 1'b1)  begin n_mis++; $display("FAIL reg_yq_high: got %b need 1", yq_s); end
        n_cmp++; if (cnt_s !== 2'd1) begin n_mis++; $display("FAIL reg_cnt_hold: got %0d need 1", cnt_s); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (cnt_s !== exp_cnt[i]) begin n_mis++; $display("FAIL sat_cnt edge %0d: got %0d need %0d", i, cnt_s, exp_cnt[i]); end
        end
        n_cmp++; if (cnt_p !== 8'd5) begin n_mis++; $display("FAIL sat_cnt_wide: got %0d need 5", cnt_p); end
    endtask

    task automatic test_async_reset_mid_run();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++; if (cnt_s !== 2'd2) begin n_mis++; $display("FAIL mid_pre_cnt: got %0d need 2", cnt_s); end
        n_cmp++; if (yq_s !== 1'b0)  begin n_mis++; $display("FAIL mid_pre_yq: got %b need 0", yq_s); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (cnt_s !== 2'd0) begin n_mis++; $display("FAIL mid_cnt_cleared: got %0d need 0", cnt_s); end
        n_cmp++; if (yq_s !== 1'b1)  begin n_mis++; $display("FAIL mid_yq_set: got %b need 1", yq_s); end
        n_cmp++; if (y_s !== 1'b0)   begin n_mis++; $display("FAIL mid_y_unaffected: got %b need 0", y_s); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (yq_s !== 1'b0)  begin n_mis++; $display("FAIL mid_release_yq: got %b need 0", yq_s); end
        n_cmp++; if (cnt_s !== 2'd1) begin n_mis++; $display("FAIL mid_release_cnt: got %0d need 1", cnt_s); end
    endtask

    task automatic test_width4();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        n_cmp++; if (y_4 !== 4'b0111) begin n_mis++; $display("FAIL w4_y: got %b need 0111", y_4); end
        @(posedge clk); #1;
        n_cmp++; if (yq_4 !== 4'b0111) begin n_mis++; $display("FAIL w4_yq: got %b need 0111", yq_4); end
        n_cmp++; if (cnt_4 !== 8'd0)   begin n_mis++; $display("FAIL w4_cnt_hold: got %0d need 0", cnt_4); end
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1110;
        @(posedge clk); #1;
        n_cmp++; if (y_4 !== 4'b0001)  begin n_mis++; $display("FAIL w4_y_partial: got %b need 0001", y_4); end
        n_cmp++; if (cnt_4 !== 8'd0)   begin n_mis++; $display("FAIL w4_cnt_partial: got %0d need 0", cnt_4); end
        @(negedge clk);
        b4 = 4'b1111;
        @(posedge clk); #1;
        n_cmp++; if (y_4 !== 4'b0000)  begin n_mis++; $display("FAIL w4_y_zero: got %b need 0000", y_4); end
        n_cmp++; if (cnt_4 !== 8'd1)   begin n_mis++; $display("FAIL w4_cnt_inc: got %0d need 1", cnt_4); end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_comb_sweep();
        test_register_path();
        test_saturation();
        test_async_reset_mid_run();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
